// File: rtl/load_store_unit.sv
// load_store_unit
//   RV32I memory-access stage. Takes the ALU sum as the effective byte
//   address and performs LB/LH/LW/LBU/LHU/SB/SH/SW over a word-wide
//   req/ack bus, one access at a time.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle request, sampled only in IDLE
//   is_store, funct3  access kind (funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU)
//   address           effective byte address
//   store_data        rs2 value
//   busy              high from the cycle after an accepted start through done
//   done              one-cycle completion pulse
//   load_data, fault  result and status (00 ok, 01 misaligned, 10 illegal,
//                     11 bus timeout); valid with done, held until next done
//   mem_*             word bus: req/we/addr/wdata/wstrb out, ack/rdata in
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The timeout fires while the counter still reads TIMEOUT-1: the cycle
  // in which it would reach TIMEOUT without an ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic             illegal, misaligned, timeout_hit;

  // Replicate the store operand across lanes so any strobe pattern
  // picks up the right bytes.
  function automatic logic [31:0] steer_wdata(input logic [2:0] f3,
                                              input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   steer_wdata = {4{sd[7:0]}};
      2'b01:   steer_wdata = {2{sd[15:0]}};
      default: steer_wdata = sd;
    endcase
  endfunction

  function automatic logic [3:0] steer_wstrb(input logic st, input logic [2:0] f3,
                                             input logic [1:0] off);
    if (!st)                 steer_wstrb = 4'b0000;
    else if (f3[1:0] == 2'b00) steer_wstrb = 4'b0001 << off;
    else if (f3[1:0] == 2'b01) steer_wstrb = 4'b0011 << {off[1], 1'b0};
    else                     steer_wstrb = 4'b1111;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] w,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    b_s = w[{off, 3'b000} +: 8];
    h_s = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  ext_s = 32'(b_s);
      3'b001:  ext_s = 32'(h_s);
      3'b100:  ext_s = {24'd0, b_s};
      3'b101:  ext_s = {16'd0, h_s};
      default: ext_s = w;
    endcase
    extract_load = ext_s;
  endfunction

  assign illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                   (is_store && funct3[2]);
  assign misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                      ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
  assign timeout_hit = (cnt == CNT_LAST);

  assign busy    = (state != IDLE);
  assign mem_req = (state == ACCESS);
  assign done    = (state == FINISH);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (illegal || misaligned) ? FINISH : ACCESS;
      ACCESS:  if (mem_ack || timeout_hit) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= 4'b0000;
      load_data  <= '0;
      fault      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            off_q      <= address[1:0];
            mem_we     <= is_store;
            mem_addr   <= {address[31:2], 2'b00};
            mem_wdata  <= steer_wdata(funct3, store_data);
            mem_wstrb  <= steer_wstrb(is_store, funct3, address[1:0]);
            // Faulted requests resolve here and skip the bus entirely.
            if (illegal) begin
              fault     <= 2'b10;
              load_data <= '0;
            end else if (misaligned) begin
              fault     <= 2'b01;
              load_data <= '0;
            end
          end
        end
        ACCESS: begin
          // An ack in the timeout cycle still counts as a success.
          if (mem_ack) begin
            fault     <= 2'b00;
            load_data <= is_store_q ? 32'd0 : extract_load(mem_rdata, funct3_q, off_q);
          end else if (timeout_hit) begin
            fault     <= 2'b11;
            load_data <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. It takes the ALU sum (rs1 + immediate) as the effective address and performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) over a simple req/ack word-wide data bus. It provides byte-lane steering, load sign/zero extension, misalignment and illegal-funct3 detection, and a bus timeout. One access is in flight at a time; the core stalls on `busy`.

Parameters:
- TIMEOUT, default 255: number of cycles in ACCESS without `mem_ack` before the access is abandoned with a fault. Must be ≥1. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; everything is updated on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- address  in  32  effective byte address, taken from the ALU result.
- store_data  in  32  rs2 value.
- busy  out  1  high from the cycle after `start` is accepted until `done` is issued (inclusive).
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid when `done` is high; held until the next `done`.
- fault  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout; valid and held like `load_data`.
- mem_req  out  1  bus request.
- mem_we  out  1  write enable; valid while `mem_req` is high.
- mem_addr  out  32  word address, {address[31:2], 2'b00}.
- mem_wdata  out  32  lane-steered store data.
- mem_wstrb  out  4  byte strobes; 0000 on loads.
- mem_ack  in  1  one-cycle acknowledge; on loads, `mem_rdata` is valid in the same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (rst_n low at an edge) clears all outputs to 0, puts the FSM in IDLE and clears the timeout counter. This applies even mid-access: `mem_req` is low after that edge. A later `mem_ack` is ignored.
- FSM states: IDLE, ACCESS, FINISH.
- IDLE, `start` = 1:
  - Latch is_store, funct3, address[1:0], store_data and the word address.
  - Checks are applied in this order:
    - Illegal: funct3 ∈ {011, 110, 111}, or a store with funct3[2] = 1. Record fault 10 and go to FINISH.
    - Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] ≠ 00. Record fault 01 and go to FINISH.
    - Otherwise go to ACCESS with `mem_req` = 1 from the next cycle.
  - A faulted access never raises `mem_req`.
- ACCESS:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_wstrb` are held stable.
  - Each cycle without `mem_ack`, the counter increments.
  - `mem_ack` = 1: capture `mem_rdata`, drop `mem_req` at the next edge, go to FINISH.
  - Counter reaches TIMEOUT with no ack: drop `mem_req`, fault 11, go to FINISH.
  - If `mem_ack` arrives in the same cycle the counter reaches TIMEOUT, the ack wins (fault 00).
- FINISH: `done` = 1 for exactly one cycle; `load_data` and `fault` update in this cycle; return to IDLE. `busy` falls the cycle after FINISH.
- Latency: with `start` in cycle 0 and ack in the first ACCESS cycle, `mem_req` is high in cycle 1, `done` is high in cycle 2. A faulted start gives `done` in cycle 1. A back-to-back `start` is accepted in the cycle after `done`.
- `start` while not in IDLE is ignored (no queueing). `mem_ack` outside ACCESS is ignored.
- Store steering, with off = address[1:0]:
  - SB: wdata = {4{store_data[7:0]}}, wstrb = 0001 << off.
  - SH: wdata = {2{store_data[15:0]}}, wstrb = 0011 << {off[1], 0}.
  - SW: wdata = store_data, wstrb = 1111.
- Load extraction from the captured word:
  - B/BU: byte at lane off, sign- or zero-extended.
  - H/HU: half at {off[1], 0}, sign- or zero-extended.
  - W: whole word.
- On stores and on any fault, `load_data` = 0.

Test Plan:
- LB: address = 0x1003, mem_rdata = 0x80FF_1234, ack in the first ACCESS cycle → mem_addr = 0x1000, wstrb = 0000, done in cycle 2, load_data = 0xFFFF_FF80, fault 00.
- LHU: address = 0x2002, mem_rdata = 0xBEEF_0000 → load_data = 0x0000_BEEF. Repeat as LH → 0xFFFF_BEEF.
- SB: address = 0x0101, store_data = 0x1234_56A5, ack delayed 3 cycles → wstrb = 0010, wdata = 0xA5A5_A5A5, mem_req high exactly 4 cycles, done 1 cycle after ack, busy drops after done.
- Faults:
  - LW at 0x0006 → done in cycle 1, fault 01, mem_req never high.
  - funct3 = 011 → fault 10.
  - SB with funct3 = 100 → fault 10.
- Timeout: TIMEOUT = 4, SW with no ack → mem_req high 4 cycles, then done with fault 11. A late mem_ack in IDLE causes no activity. Also drive ack in the same cycle the counter reaches TIMEOUT → fault 00.
- Start while busy / reset mid-access:
  - A second start during ACCESS is ignored: one done only, data from the first access.
  - rst_n low during ACCESS → mem_req, busy and done are 0 after that edge. After release, a fresh LW completes normally.
